// File: rtl/mem_ctrl_if.sv
// Processor-side request/response channel of mem_ctrl.
// master = processor (request source, response sink); slave = mem_ctrl.
interface mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Load/store controller in front of a 256 x 32 single-port RAM with registered read.
// Build option MEMCTL_RMW_EN adds read-modify-write for byte/half stores; otherwise they error.
module mem_ctrl (
  input  logic        clock,
  input  logic        reset,
  mem_ctrl_if.slave   bus,
  output logic [8:0]  addr,
  output logic        wr,
  output logic [31:0] wdata,
  output logic        rd,
  input  logic [31:0] rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WIDX_W = 8;
  localparam int unsigned ADDR_W = 9;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_CAPT,
    ST_ISSUE,
    RESP
`ifdef MEMCTL_RMW_EN
    ,
    RMW_RD,
    RMW_CAPT,
    RMW_WR
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [1:0]          lane_q, lane_d;
`ifdef MEMCTL_RMW_EN
  logic [WIDX_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   st_data_q, st_data_d;
`endif

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                req_err_c;
  logic [ADDR_W-1:0]   req_ram_addr_c;

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [1:0]        lane
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      SZ_HALF: res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: res = word;
    endcase
    load_extract = res;
  endfunction

`ifdef MEMCTL_RMW_EN
  // Overwrite the addressed byte/half lane of the old word with the store data.
  function automatic logic [DATA_W-1:0] merge_lane(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] data
  );
    logic [DATA_W-1:0] res;
    res = word;
    if (size == SZ_BYTE) res[{lane, 3'b000} +: 8] = data[7:0];
    else                 res[{lane[1], 4'b0000} +: 16] = data[15:0];
    merge_lane = res;
  endfunction
`endif

  // Misaligned/illegal requests are rejected without touching the RAM.
  always_comb begin
    req_err_c = (bus.req_size == SZ_ILL) ||
                ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`ifndef MEMCTL_RMW_EN
    if (bus.req_wr && (bus.req_size != SZ_WORD)) req_err_c = 1'b1;
`endif
    req_ram_addr_c = {1'b0, bus.req_addr[9:2]};
  end

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign addr           = addr_q;
  assign wr             = wr_q;
  assign wdata          = wdata_q;
  assign rd             = rd_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      lane_q       <= 2'b00;
`ifdef MEMCTL_RMW_EN
      word_q       <= '0;
      st_data_q    <= '0;
`endif
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lane_q       <= lane_d;
`ifdef MEMCTL_RMW_EN
      word_q       <= word_d;
      st_data_q    <= st_data_d;
`endif
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // RAM strobes default low with address/data zeroed; each state raises them for one cycle.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lane_d       = lane_q;
`ifdef MEMCTL_RMW_EN
    word_d       = word_q;
    st_data_d    = st_data_q;
`endif
    addr_d       = '0;
    wr_d         = 1'b0;
    wdata_d      = '0;
    rd_d         = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d = bus.req_size;
          sgn_d  = bus.req_signed;
          lane_d = bus.req_addr[1:0];
`ifdef MEMCTL_RMW_EN
          word_d    = bus.req_addr[9:2];
          st_data_d = bus.req_wdata;
`endif
          if (req_err_c) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else if (!bus.req_wr) begin
            rd_d    = 1'b1;
            addr_d  = req_ram_addr_c;
            state_d = LD_ISSUE;
          end else if (bus.req_size == SZ_WORD) begin
            wr_d    = 1'b1;
            addr_d  = req_ram_addr_c;
            wdata_d = bus.req_wdata;
            state_d = ST_ISSUE;
          end
`ifdef MEMCTL_RMW_EN
          else begin
            rd_d    = 1'b1;
            addr_d  = req_ram_addr_c;
            state_d = RMW_RD;
          end
`endif
        end
      end

      LD_ISSUE: state_d = LD_CAPT;

      LD_CAPT: begin
        resp_rdata_d = load_extract(rdata, size_q, sgn_q, lane_q);
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end

      ST_ISSUE: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end

`ifdef MEMCTL_RMW_EN
      RMW_RD: state_d = RMW_CAPT;

      RMW_CAPT: begin
        wr_d    = 1'b1;
        addr_d  = {1'b0, word_q};
        wdata_d = merge_lane(rdata, size_q, lane_q, st_data_q);
        state_d = RMW_WR;
      end

      RMW_WR: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
`endif

      RESP: begin
        // Error requests enter RESP with resp_valid still low, giving them one cycle of latency.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
        end else if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  a_rd_wr_excl: assert property (@(posedge clock) disable iff (reset) !(rd && wr));
  a_idle_zero:  assert property (@(posedge clock) disable iff (reset)
                                 (!rd && !wr) |-> (addr == '0 && wdata == '0));
  a_rd_pulse:   assert property (@(posedge clock) disable iff (reset) rd |=> !rd);
  a_wr_pulse:   assert property (@(posedge clock) disable iff (reset) wr |=> !wr);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: RAM model, word-level reference memory, directed + random requests.
// Honours MEMCTL_RMW_EN the same way as the design.
module tb_mem_ctrl;

`ifdef MEMCTL_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_ctrl_if bus ();
  logic [8:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        rd;
  logic [31:0] rdata;

  mem_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .addr  (addr),
    .wr    (wr),
    .wdata (wdata),
    .rd    (rd),
    .rdata (rdata)
  );

  // RAM model: registered read, data visible only the cycle after rd; garbage otherwise.
  logic [31:0] ram [256];
  logic [31:0] ram_q;
  logic        rd_q;
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clock) begin
    rd_q <= rd;
    if (rd) ram_q <= ram[addr[7:0]];
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (wr) ram[addr[7:0]] <= wdata;
  end
  assign rdata = rd_q ? ram_q : 32'hDEAD_BEEF;

  // Bus activity monitor: cumulative pulse counts and invariant violations.
  int   rd_cnt = 0, wr_cnt = 0, viol = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (rd) rd_cnt++;
      if (wr) wr_cnt++;
      if (rd && wr) viol++;
      if (!rd && !wr && (addr != 9'd0 || wdata != 32'd0)) viol++;
      if ((rd && prev_rd) || (wr && prev_wr)) viol++;
      if ((rd || wr) && addr[8]) viol++;
    end
    prev_rd = rd;
    prev_wr = wr;
  end

  logic [31:0] ref_mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(posedge clock); #1;
    bd_we = 1'b0;
  endtask

  // Issue one request, check latency, response, hold behaviour, RAM traffic and final RAM state.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                         input logic [31:0] wd, input int stall, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_data, v, mask, old;
    int          sh, exp_lat, exp_rd, exp_wr, lat, n, rd0, wr0, v0;
    logic [31:0] held;
    sh      = 8 * int'(a[1:0]);
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
              (!RMW_EN && w && sz != 2'd2);
    exp_data = 32'd0; exp_rd = 0; exp_wr = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 2; exp_rd = 1;
      v = ref_mem[a[9:2]] >> sh;
      if (sz == 2'd0) begin
        v = v & 32'hFF;
        if (sg && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2'd1) begin
        v = v & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end
      exp_data = v;
    end else begin
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      old  = ref_mem[a[9:2]];
      ref_mem[a[9:2]] = (old & ~(mask << sh)) | ((wd & mask) << sh);
      exp_lat = (sz == 2'd2) ? 1 : 3;
      exp_rd  = (sz == 2'd2) ? 0 : 1;
      exp_wr  = 1;
    end

    n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clock); #1; n++; end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt; v0 = viol;

    bus.req_valid = 1'b1; bus.req_wr = w; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_wr = $urandom_range(0, 1); bus.req_size = 2'($urandom_range(0, 3));
    bus.req_signed = $urandom_range(0, 1); bus.req_addr = 10'($urandom); bus.req_wdata = $urandom;

    lat = 0;
    while (!bus.resp_valid && lat < 12) begin @(posedge clock); #1; lat++; end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_rdata", bus.resp_rdata, exp_data);
    check("resp_err", 32'(bus.resp_err), 32'(exp_err));
    got  = bus.resp_rdata;
    held = bus.resp_rdata;

    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_rdata", bus.resp_rdata, held);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    check("resp_drop", 32'(bus.resp_valid), 32'd0);
    check("req_ready_rise", 32'(bus.req_ready), 32'd1);
    check("rd_pulses", 32'(rd_cnt - rd0), 32'(exp_rd));
    check("wr_pulses", 32'(wr_cnt - wr0), 32'(exp_wr));
    check("bus_invariants", 32'(viol - v0), 32'd0);
    if (w) check("ram_word", ram[a[9:2]], ref_mem[a[9:2]]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          wr0, rd0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Fill RAM while reset is held, then check reset values.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) bd_write(8'(i), $urandom);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_ram_strobes", {30'd0, rd, wr}, 32'd0);
    check("rst_addr_wdata", wdata | 32'(addr), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Word store then word load.
    run_req(1'b1, 2'd2, 1'b0, 10'h000, 32'h2245_0000, 0, got);
    run_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, 0, got);
    check("plan_word_load", got, 32'h2245_0000);

    // Byte store into a preset word, then sub-word loads.
    bd_write(8'd1, 32'h10F0_0010);
    run_req(1'b1, 2'd0, 1'b0, 10'h005, 32'h0000_00A5, 0, got);
`ifdef MEMCTL_RMW_EN
    check("plan_rmw_word", ram[1], 32'h10F0_A510);
`endif
    run_req(1'b0, 2'd0, 1'b1, 10'h005, 32'h0, 0, got);
`ifdef MEMCTL_RMW_EN
    check("plan_sbyte", got, 32'hFFFF_FFA5);
`endif
    run_req(1'b0, 2'd0, 1'b0, 10'h005, 32'h0, 0, got);
`ifdef MEMCTL_RMW_EN
    check("plan_ubyte", got, 32'h0000_00A5);
`endif
    run_req(1'b0, 2'd1, 1'b1, 10'h006, 32'h0, 0, got);
    check("plan_shalf", got, 32'h0000_10F0);
    run_req(1'b0, 2'd0, 1'b1, 10'h007, 32'h0, 0, got);
    check("plan_sbyte7", got, 32'h0000_0010);

    // Error cases.
    run_req(1'b0, 2'd2, 1'b0, 10'h002, 32'h0, 0, got);
    run_req(1'b1, 2'd1, 1'b0, 10'h001, 32'h1234, 0, got);
    run_req(1'b0, 2'd3, 1'b0, 10'h010, 32'h0, 0, got);
    run_req(1'b1, 2'd0, 1'b0, 10'h005, 32'h77, 1, got);

    // Back-pressured load.
    run_req(1'b0, 2'd2, 1'b0, 10'h004, 32'h0, 5, got);

    // Reset two edges after accepting a byte store (RMW_CAPT when RMW is built in).
    wr0 = wr_cnt; rd0 = rd_cnt;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 10'h005; bus.req_wdata = 32'h0000_005A;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_strobes", {30'd0, rd, wr}, 32'd0);
    check("midrst_addr_wdata", wdata | 32'(addr), 32'd0);
    check("midrst_resp", {bus.resp_rdata[30:0], bus.resp_valid} | 32'(bus.resp_err), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    check("midrst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("midrst_rd_count", 32'(rd_cnt - rd0), RMW_EN ? 32'd1 : 32'd0);
    check("midrst_word_kept", ram[1], ref_mem[1]);

    // Random traffic against the reference memory.
    for (int i = 0; i < 300; i++) begin
      logic [9:0] ra;
      ra = (i % 2 == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ra, $urandom, $urandom_range(0, 2), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
